// File: rtl/openofdm_rx_pkg.sv
// openofdm_rx_pkg: register word indices and AXI response code shared by the rx control block
package openofdm_rx_pkg;
  localparam int REG_STATE_HIST   = 20;
  localparam int REG_HDR_CNT      = 21;
  localparam int REG_FCS_OK_CNT   = 22;
  localparam int REG_FCS_FAIL_CNT = 23;
  localparam int REG_CNT_CLR      = 24;
  localparam logic [1:0] OKAY = 2'b00;
endpackage

// File: rtl/openofdm_rx_ctrl_regs_if.sv
// openofdm_rx_ctrl_regs_if: AXI-lite bundle with master/slave views
interface openofdm_rx_ctrl_regs_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/openofdm_rx_sat_cnt.sv
// openofdm_rx_sat_cnt: saturating event counter with a clear that overrides increment
module openofdm_rx_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clock)
    count <= (reset || clr) ? '0 : (inc && !(&count)) ? count + WIDTH'(1) : count;
endmodule

// File: rtl/openofdm_rx_ctrl_regs.sv
// openofdm_rx_ctrl_regs: AXI-lite config/status registers; packet counters built only with OPENOFDM_RX_PKT_CNT_EN
module openofdm_rx_ctrl_regs
  import openofdm_rx_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int NUM_CFG_REGS       = 8,
  parameter int STATE_WIDTH        = 4,
  parameter int HIST_DEPTH         = 8,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  openofdm_rx_ctrl_regs_if.slave    s00_axi,
  input  logic [STATE_WIDTH-1:0]    state,
  input  logic                      pkt_header_valid_strobe,
  input  logic                      fcs_out_strobe,
  input  logic                      fcs_ok,
  output logic [NUM_CFG_REGS*32-1:0] cfg_out,
  output logic                      core_rst
);
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;
  localparam int HW = HIST_DEPTH * STATE_WIDTH;
  localparam logic [31:0] HIST_MASK = 32'((64'd1 << HW) - 64'd1);
  logic [31:0] cfg   [NUM_CFG_REGS];
  logic [31:0] cfg_d [NUM_CFG_REGS];
  logic [31:0] hist;
  logic [31:0] rd_mux;
  logic [STATE_WIDTH-1:0] prev_state;
  logic wr_en;
  logic rd_en;
  int widx;
  int ridx;
  assign wr_en = s00_axi.awready & s00_axi.awvalid & s00_axi.wready & s00_axi.wvalid;
  assign rd_en = s00_axi.arready & s00_axi.arvalid;
  assign widx = int'(s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2]);
  assign ridx = int'(s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2]);
  assign s00_axi.bresp = OKAY;
  assign s00_axi.rresp = OKAY;
  always_ff @(posedge clock)
    if (reset) begin
      s00_axi.awready <= 1'b0;
      s00_axi.wready  <= 1'b0;
      s00_axi.bvalid  <= 1'b0;
      s00_axi.arready <= 1'b0;
      s00_axi.rvalid  <= 1'b0;
      s00_axi.rdata   <= '0;
    end else begin
      s00_axi.awready <= ~s00_axi.awready & s00_axi.awvalid & s00_axi.wvalid & ~s00_axi.bvalid;
      s00_axi.wready  <= ~s00_axi.awready & s00_axi.awvalid & s00_axi.wvalid & ~s00_axi.bvalid;
      s00_axi.bvalid  <= wr_en | (s00_axi.bvalid & ~s00_axi.bready);
      s00_axi.arready <= ~s00_axi.arready & s00_axi.arvalid & ~s00_axi.rvalid;
      s00_axi.rvalid  <= rd_en | (s00_axi.rvalid & ~s00_axi.rready);
      s00_axi.rdata   <= rd_en ? rd_mux : s00_axi.rdata;
    end
  always_comb begin
    cfg_d = cfg;
    for (int k = 0; k < NUM_CFG_REGS; k++)
      for (int b = 0; b < NB; b++)
        if (wr_en && widx == k && s00_axi.wstrb[b])
          cfg_d[k][8*b+:8] = s00_axi.wdata[8*b+:8];
  end
  always_ff @(posedge clock) begin
    if (reset)
      cfg <= '{default: '0};
    else
      cfg <= cfg_d;
    core_rst   <= reset | cfg_d[0][0];
    prev_state <= reset ? '0 : state;
    hist       <= reset ? '0 : (state != prev_state) ? {hist[31-STATE_WIDTH:0], state} & HIST_MASK : hist;
  end
  for (genvar i = 0; i < NUM_CFG_REGS; i++) begin : g_cfg
    assign cfg_out[32*i+:32] = cfg[i];
  end
`ifdef OPENOFDM_RX_PKT_CNT_EN
  logic cnt_clr;
  logic [CNT_WIDTH-1:0] hdr_cnt;
  logic [CNT_WIDTH-1:0] ok_cnt;
  logic [CNT_WIDTH-1:0] fail_cnt;
  logic unused;
  assign unused = ^{s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};
  assign cnt_clr = wr_en & (widx == REG_CNT_CLR) & s00_axi.wstrb[0] & s00_axi.wdata[0];
  openofdm_rx_sat_cnt #(.WIDTH(CNT_WIDTH)) u_hdr_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (pkt_header_valid_strobe),
    .clr   (cnt_clr),
    .count (hdr_cnt)
  );
  openofdm_rx_sat_cnt #(.WIDTH(CNT_WIDTH)) u_ok_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (fcs_out_strobe & fcs_ok),
    .clr   (cnt_clr),
    .count (ok_cnt)
  );
  openofdm_rx_sat_cnt #(.WIDTH(CNT_WIDTH)) u_fail_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (fcs_out_strobe & ~fcs_ok),
    .clr   (cnt_clr),
    .count (fail_cnt)
  );
`else
  logic unused;
  assign unused = ^{s00_axi.awaddr[1:0], s00_axi.araddr[1:0], pkt_header_valid_strobe, fcs_out_strobe, fcs_ok};
`endif
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CFG_REGS; k++)
      if (ridx == k) rd_mux = cfg[k];
    if (ridx == REG_STATE_HIST) rd_mux = hist;
`ifdef OPENOFDM_RX_PKT_CNT_EN
    if (ridx == REG_HDR_CNT)      rd_mux = 32'(hdr_cnt);
    if (ridx == REG_FCS_OK_CNT)   rd_mux = 32'(ok_cnt);
    if (ridx == REG_FCS_FAIL_CNT) rd_mux = 32'(fail_cnt);
`endif
  end
endmodule

// File: doc/openofdm_rx_ctrl_regs.md
OPENOFDM_RX_CTRL_REGS -- requirements
Module: openofdm_rx_ctrl_regs

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  C_S_AXI_DATA_WIDTH, 32, AXI-lite data width (only 32 supported).
  C_S_AXI_ADDR_WIDTH, 7, AXI-lite byte address width; word index = addr[ADDR_WIDTH-1:2].
  NUM_CFG_REGS, 8, R/W config registers at word 0..NUM_CFG_REGS-1 (1..20).
  STATE_WIDTH, 4, width of the core state input.
  HIST_DEPTH, 8, state-history entries; HIST_DEPTH*STATE_WIDTH <= 32.
  CNT_WIDTH, 32, packet counter width (1..32).
REQ-002 Ports, one per line (name, direction, width, meaning):
  clock, in, 1, single clock for the whole block.
  reset, in, 1, synchronous, active-high.
  s00_axi_aw*/w*/b*/ar*/r*, AXI-lite slave, standard widths, register access.
  state, in, STATE_WIDTH, current dot11 decoder state.
  pkt_header_valid_strobe, in, 1, one-cycle pulse for each decoded header.
  fcs_out_strobe, in, 1, one-cycle pulse qualifying fcs_ok.
  fcs_ok, in, 1, FCS result.
  cfg_out, out, NUM_CFG_REGS*32, concatenated config registers; reg k at bits [32k+31:32k].
  core_rst, out, 1, registered reset request to the decoder core.

Function
REQ-003 Write: AWREADY and WREADY SHALL pulse together for one cycle when AWVALID, WVALID and !BVALID are all true; BVALID SHALL rise on the next cycle and hold until BREADY; BRESP = 00.
REQ-004 Writes SHALL honour WSTRB per byte; writes to read-only or unmapped words SHALL be accepted and ignored.
REQ-005 Read: ARREADY SHALL pulse for one cycle when ARVALID and !RVALID are true; RVALID with RDATA SHALL follow one cycle later, held stable until RREADY; RRESP = 00.
REQ-006 Map: words 0..NUM_CFG_REGS-1 are config (R/W); 20 is state history (RO); 21 is header count (RO); 22 is FCS-ok count (RO); 23 is FCS-fail count (RO); 24 is the counter clear (W1C pulse, bit0; reads 0). All other words SHALL read 0.
REQ-007 History: when state differs from its previous-cycle value, word 20 SHALL shift left by STATE_WIDTH and load the new state into the LSBs; the oldest entry drops; unused MSBs are 0.
REQ-008 Counters: each SHALL increment by 1 on its qualifying strobe and saturate at 2^CNT_WIDTH-1. FCS-ok counts fcs_out_strobe&fcs_ok; FCS-fail counts fcs_out_strobe&!fcs_ok.
REQ-009 A clear write that coincides with an increment SHALL win: the counter reads 0 on the next cycle.
REQ-010 core_rst SHALL be a register equal to reset | cfg reg0 bit0, updating one cycle after a write to cfg reg0.
REQ-011 A simultaneous AXI read and write SHALL both complete; a read of a word being written in the same cycle SHALL return the pre-write value.

Reset
REQ-012 On reset: all config registers, history, counters, BVALID, RVALID, AWREADY, WREADY and ARREADY SHALL be 0, and RDATA SHALL be 0; core_rst SHALL be 1 in the cycle after reset is asserted.
REQ-013 Reset during an outstanding BVALID/RVALID SHALL drop the response without waiting for BREADY/RREADY.

Configuration
REQ-014 Macro OPENOFDM_RX_PKT_CNT_EN: when defined, the counters (words 21-24) are present. When undefined, no counter logic SHALL exist, words 21-23 SHALL read 0 and writes to word 24 SHALL be ignored.

Structure
REQ-015 Package openofdm_rx_pkg SHALL hold the word-index constants (REG_STATE_HIST=20, REG_HDR_CNT=21, REG_FCS_OK_CNT=22, REG_FCS_FAIL_CNT=23, REG_CNT_CLR=24) and the AXI response constant OKAY.
REQ-016 Sub-module openofdm_rx_sat_cnt (parametrised width; ports inc, clr, count) SHALL be instantiated three times.

Verification
REQ-017 Write 0x12345678 to word 2 with WSTRB=0011 after reset -> word 2 reads 0x00005678, and cfg_out[95:64]=0x00005678.
REQ-018 State sequence 1,1,3,5 (STATE_WIDTH=4) -> word 20 reads 0x00000135.
REQ-019 CNT_WIDTH=4, 17 header strobes -> word 21 reads 0xF; then write word 24 = 1 in the same cycle as a strobe -> next read is 0.
REQ-020 FCS strobes with ok = 1,0,0 -> word 22 = 1 and word 23 = 2; with the macro undefined, both read 0.
REQ-021 Hold BREADY low for 5 cycles after a write -> BVALID stays high, AWREADY stays low, and a second AW/W is not accepted until BREADY.
REQ-022 Write 1 to word 0 -> core_rst = 1 one cycle later; write 0 -> core_rst = 0; assert reset while RVALID is pending -> RVALID = 0 on the next cycle.
